// File: rtl/sigmoid_IP.sv
// sigmoid_IP: behavioural stand-in for the vendor sigmoid ROM (registered read).
// Address is the signed value sat[15:4]; q approximates 256*sigmoid with a clamped linear ramp.
module sigmoid_IP (
  input  logic        clock,
  input  logic [11:0] address,
  output logic [7:0]  q
);

  logic [10:0] w_ramp;
  logic [7:0]  w_val;
  logic        w_unused_lsb;
  logic [7:0]  r_q;

  // 128 + address/8, computed in 11-bit two's complement and then clamped to 0..255
  assign w_ramp       = {{2{address[11]}}, address[11:3]} + 11'd128;
  assign w_unused_lsb = ^address[2:0];

  always_comb begin
    w_val = w_ramp[7:0];
    if (w_ramp[10])
      w_val = '0;
    else if (w_ramp[9:8] != 2'b00)
      w_val = '1;
  end

  always_ff @(posedge clock) begin
    r_q <= w_val;
  end

  assign q = r_q;

endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: time-multiplexed neuron (LANES MACs per beat, bias, 16-bit saturation, activation).
// Build option NEURON_RELU_EN: ReLU activation register replaces the sigmoid_IP lookup.
module neuron_mac_seq #(
  parameter int N_INPUTS = 37,
  parameter int LANES    = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  // Entries left at the INT_MIN default resolve to weight i+1 (bias N_INPUTS+1).
  parameter int WEIGHTS [N_INPUTS+1] = '{default: int'(32'h8000_0000)}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_INPUTS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       busy
);

  localparam int BEATS   = (N_INPUTS + LANES - 1) / LANES;
  localparam int SLOTS   = BEATS * LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PROD_W  = DATA_W + 16;
  localparam int W_UNSET = int'(32'h8000_0000);
  localparam int BIAS_RAW = WEIGHTS[N_INPUTS];
  localparam logic signed [15:0] BIAS =
    (BIAS_RAW == W_UNSET) ? 16'(N_INPUTS + 1) : 16'(BIAS_RAW);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_BIAS, S_SAT, S_ACT, S_OUT} state_t;

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic [BEAT_W-1:0]         r_beat;
  logic signed [15:0]        r_sat;
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_x [N_INPUTS];

  logic signed [DATA_W-1:0]  w_in  [N_INPUTS];
  logic signed [DATA_W-1:0]  w_x   [SLOTS];
  logic signed [15:0]        w_wgt [SLOTS];
  logic signed [PROD_W-1:0]  w_prod [LANES];
  logic signed [ACC_W-1:0]   w_beat_sum;
  logic signed [15:0]        w_sat_next;
  logic                      w_unused_sat;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_unpack
    assign w_in[g] = in_data[g*DATA_W +: DATA_W];
  end

  // Slots past N_INPUTS in the last beat carry zero data and zero weight.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < N_INPUTS) begin : g_used
      localparam int RAW = WEIGHTS[g];
      assign w_wgt[g] = (RAW == W_UNSET) ? 16'(g + 1) : 16'(RAW);
      assign w_x[g]   = r_x[g];
    end else begin : g_pad
      assign w_wgt[g] = '0;
      assign w_x[g]   = '0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IDX_W-1:0] w_idx;
    assign w_idx     = IDX_W'(r_beat) * IDX_W'(LANES) + IDX_W'(k);
    assign w_prod[k] = PROD_W'(w_x[w_idx]) * PROD_W'(w_wgt[w_idx]);
  end

  always_comb begin
    w_beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++)
      w_beat_sum = w_beat_sum + ACC_W'(w_prod[k]);
  end

  always_comb begin
    w_sat_next = 16'(r_acc);
    if (r_acc > SAT_MAX)
      w_sat_next = 16'sh7fff;
    else if (r_acc < SAT_MIN)
      w_sat_next = 16'sh8000;
  end

`ifdef NEURON_RELU_EN
  logic [7:0] r_out_data;
  logic [7:0] w_relu;
  // Non-negative 16-bit values shifted right by 7 never exceed 255, so no upper clamp is needed.
  assign w_relu       = r_sat[15] ? '0 : r_sat[14:7];
  assign w_unused_sat = ^r_sat[6:0];
  assign out_data     = r_out_data;
`else
  logic [7:0] w_lut_q;
  sigmoid_IP u_sigmoid (
    .clock   (clk),
    .address (r_sat[15:4]),
    .q       (w_lut_q)
  );
  assign w_unused_sat = ^r_sat[3:0];
  assign out_data     = r_out_valid ? w_lut_q : '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_beat      <= '0;
      r_sat       <= '0;
      r_out_valid <= 1'b0;
`ifdef NEURON_RELU_EN
      r_out_data  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_x     <= w_in;
            r_acc   <= '0;
            r_beat  <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_beat_sum;
          if (r_beat == BEAT_W'(BEATS - 1))
            r_state <= S_BIAS;
          else
            r_beat <= r_beat + 1'b1;
        end
        S_BIAS: begin
          r_acc   <= r_acc + ACC_W'(BIAS);
          r_state <= S_SAT;
        end
        S_SAT: begin
          r_sat   <= w_sat_next;
          r_state <= S_ACT;
        end
        S_ACT: begin
          r_out_valid <= 1'b1;
`ifdef NEURON_RELU_EN
          r_out_data  <= w_relu;
`endif
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;

endmodule
